// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path and the scan-code decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  localparam int unsigned PS2_FRAME_BITS  = 11;
  localparam int unsigned TIMEOUT_CYC_DEF = 50000;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Odd parity: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// PS/2 pins plus the byte handshake towards the scan-code decoder.
interface ps2_rx_fifo_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data, nextdata_n,
    input  data, ready, overflow, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, nextdata_n,
    output data, ready, overflow, frame_err
  );
endinterface

// File: rtl/ps2_byte_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head data decoded from registered storage.
module ps2_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a byte FIFO drained via ready/nextdata_n.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk_50m,
  input  logic         clr_n,
  ps2_rx_fifo_if.slave bus
);

  localparam int unsigned BIT_W  = $clog2(PS2_FRAME_BITS);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  rx_state_e         state_q;
  logic [BIT_W-1:0]  bitcnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic [7:0]        shreg_q;
  logic              par_q;
  logic              frame_ok_q;
  logic              frame_err_q;
  logic              overflow_q;

  logic       fall_c, bit_c, frame_ok_c;
  logic       full, empty, pop_c, push_c;
  logic [7:0] head;

  // Pin synchronisers; idle-high so reset never produces a false edge.
  always_ff @(posedge clk_50m or negedge clr_n) begin
    if (!clr_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
    end
  end

  assign fall_c     = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_c      = dat_sync_q[1];
  assign frame_ok_c = odd_parity_ok(shreg_q, par_q) & bit_c;

  assign pop_c  = ~empty & ~bus.nextdata_n;
  assign push_c = (state_q == CHECK) & frame_ok_q & (~full | pop_c);

  // Frame receive FSM; validity is judged on the stop edge so frame_err lands in the CHECK cycle.
  always_ff @(posedge clk_50m or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      idle_q      <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if ((state_q == CHECK) && frame_ok_q && full && !pop_c) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          idle_q <= '0;
          if (fall_c && !bit_c) begin
            state_q  <= RECV;
            bitcnt_q <= BIT_W'(1);
          end
        end
        RECV: begin
          if (fall_c) begin
            idle_q   <= '0;
            bitcnt_q <= bitcnt_q + BIT_W'(1);
            if (bitcnt_q <= BIT_W'(8)) begin
              shreg_q <= {bit_c, shreg_q[7:1]};
            end else if (bitcnt_q == BIT_W'(9)) begin
              par_q <= bit_c;
            end else begin
              frame_ok_q  <= frame_ok_c;
              frame_err_q <= ~frame_ok_c;
              bitcnt_q    <= '0;
              state_q     <= CHECK;
            end
          end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
            frame_err_q <= 1'b1;
            bitcnt_q    <= '0;
            idle_q      <= '0;
            state_q     <= IDLE;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
        CHECK:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk_50m),
    .rst_n   (clr_n),
    .push_i  (push_c),
    .wdata_i (shreg_q),
    .pop_i   (pop_c),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.data      = head;
  assign bus.ready     = ~empty;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host serial receiver with an 8-entry byte FIFO, sitting directly upstream of the keyboard scan-code decoder. It synchronises `ps2_clk`/`ps2_data` into `clk_50m`, deserialises 11-bit frames, checks start, parity and stop bits, and queues valid scan-code bytes. Bytes are released through the `ready`/`nextdata_n` handshake that the decoder already uses.

## Interface
- `FIFO_DEPTH`, 8: byte entries; must be a power of two.
- `TIMEOUT_CYC`, 50000: `clk_50m` cycles without a PS/2 falling edge (1 ms) before a partial frame is aborted.
- `clk_50m` in 1: single system clock, 50 MHz.
- `clr_n` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock from the pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data from the pin, asynchronous.
- `data` out 8: byte at the FIFO head; valid while `ready`=1.
- `ready` out 1: FIFO non-empty.
- `nextdata_n` in 1: active-low pop request from the consumer.
- `overflow` out 1: sticky; a valid byte was dropped because the FIFO was full.
- `frame_err` out 1: one-cycle pulse on a parity, start or stop error, or on a timeout abort.

## Operation
- **Synchronisers**
  - `ps2_clk` passes through a 3-flop synchroniser; a falling edge is detected when the last two stages read 1 then 0.
  - `ps2_data` passes through 2 flops and is sampled on the detected falling edge.
- **Receive FSM**
  - IDLE: on a falling edge with sampled data = 0 (start bit), go to RECV with `bitcnt`=1. A falling edge with data = 1 is ignored.
  - RECV: shift in 8 data bits LSB-first, then the parity bit, then the stop bit. `bitcnt` runs 1..10. When the stop bit is sampled, go to CHECK.
  - CHECK (1 cycle): the frame is valid when the XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop = 1.
    - Valid and FIFO not full: push.
    - Valid and FIFO full: drop the byte and set `overflow`.
    - Invalid: pulse `frame_err` and discard.
    - Return to IDLE in every case.
  - Timeout: in RECV, an idle counter clears on each falling edge. When it reaches `TIMEOUT_CYC`, pulse `frame_err`, clear `bitcnt` and return to IDLE.
- **FIFO**
  - Read and write pointers are log2(`FIFO_DEPTH`)+1 bits wide; the extra MSB is the wrap bit.
  - Empty: pointers equal. Full: pointers differ only in the MSB.
  - `data` = mem[rptr], decoded combinationally from registered storage.
  - Pop: on a posedge where `ready`=1 and `nextdata_n`=0, rptr increments. A pop while empty is ignored.
  - Holding `nextdata_n` low pops one byte per cycle.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - Push while full with a simultaneous pop is accepted and does not set `overflow`.
  - Pointers wrap modulo 2×`FIFO_DEPTH`.
- **Reset** (`clr_n` low, any time, including mid-frame): FSM → IDLE, `bitcnt` and idle counter → 0, pointers → 0, mem → 0, synchronisers → 1. Any partial frame is lost.
- **Reset values of outputs**: `data`=8'h00, `ready`=0, `overflow`=0, `frame_err`=0.
- **`overflow`** clears only on reset.

## Timing
- Edge detect: 3 `clk_50m` cycles after the `ps2_clk` pin falls, plus metastability uncertainty of up to 1 cycle.
- Stop bit sampled in cycle T → CHECK in T+1 → push at the end of T+1 → `ready`/`data` valid from T+2.
- Pop at posedge P → the next head byte, or `ready`=0, is visible from P+1.
- `frame_err` is high for exactly 1 cycle: T+1 for a bad frame, or the cycle in which the timeout count hits.
- Full-rate PS/2 (10–16.7 kHz) gives at least 3000 system cycles per bit, so the FSM never misses an edge.

## Structure
- Package `ps2_pkg`:
  - FSM state enum {IDLE, RECV, CHECK}.
  - `PS2_FRAME_BITS`=11.
  - Default `TIMEOUT_CYC`.
  - Scan-code constants `PS2_BREAK`=8'hF0 and `PS2_EXT`=8'hE0, shared with the decoder.
- Sub-module `ps2_byte_fifo`: generic synchronous FIFO with push, pop, full, empty and head data. The receive FSM and synchronisers stay in `ps2_rx_fifo`.

## Test plan
- Send frame for 8'h1C with correct odd parity; hold `nextdata_n`=1 → `ready` rises 2 cycles after the stop edge with `data`=8'h1C. Pulse `nextdata_n` low for 1 cycle → `ready`=0.
- Send 8'hF0 then 8'h1C back-to-back with no pops → `ready`=1, `data`=8'hF0. After the first pop → `data`=8'h1C. After the second pop → `ready`=0.
- Send 8'h1C with the parity bit flipped, then a frame with stop = 0 → one `frame_err` pulse each, `ready` stays 0, `overflow` stays 0.
- Send 9 valid frames (8'h01–8'h09) with no pops → `overflow`=1 after the 9th. Draining yields 8'h01–8'h08 in order; 8'h09 is absent.
- Fill the FIFO with 8 frames; at the CHECK cycle of a 9th frame, hold `nextdata_n`=0 → no `overflow`, the FIFO still holds 8 entries, and the 9th byte is last out.
- Stop `ps2_clk` after 5 bits for more than `TIMEOUT_CYC` → `frame_err` pulse, next full frame 8'h2A received correctly. Separately, assert `clr_n`=0 mid-frame → all outputs return to reset values asynchronously.
